// File: rtl/multichannel_variable_delay_line_pkg.sv
// Depth and tap-address helpers shared by the delay line and its channels.
package multichannel_delay_pkg;

    localparam int unsigned DELAY_BITS_DEFAULT = 4;

    function automatic int unsigned depth_of(
        input int unsigned bits
    );
        return 32'd1 << bits;
    endfunction

    // Read slot d samples behind the write slot, wrapping at the buffer depth.
    function automatic int unsigned tap_addr(
        input int unsigned wr_ptr,
        input int unsigned d,
        input int unsigned bits
    );
        return (wr_ptr - d) & (depth_of(bits) - 1);
    endfunction

    localparam int unsigned DEPTH = depth_of(DELAY_BITS_DEFAULT);

    typedef logic [DELAY_BITS_DEFAULT-1:0] ptr_t;

endpackage

// File: rtl/multichannel_variable_delay_line_channel.sv
// One channel: circular sample buffer, zero-delay bypass and output registers.
module delay_line_channel
    import multichannel_delay_pkg::*;
#(
    parameter int DATA_BITS  = 32,
    parameter int DELAY_BITS = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  CE,
    input  logic                  CLEAR,
    input  logic [DELAY_BITS-1:0] WR_PTR,
    input  logic [DELAY_BITS-1:0] FILL,
    input  logic [DELAY_BITS-1:0] DELAY,
    input  logic [DATA_BITS-1:0]  IN_VALUE,
    output logic [DATA_BITS-1:0]  OUT_VALUE,
    output logic                  OUT_VALID
);

    localparam int MEM_DEPTH = int'(depth_of(DELAY_BITS));

    logic [DATA_BITS-1:0]  mem [MEM_DEPTH];
    logic [DELAY_BITS-1:0] rd_addr;
    logic [DATA_BITS-1:0]  tap;
    logic [DATA_BITS-1:0]  next_value;
    logic                  history_ok;
    logic                  bypass;
    logic                  from_tap;

    assign rd_addr = DELAY_BITS'(tap_addr(32'(WR_PTR), 32'(DELAY), DELAY_BITS));
    assign tap        = mem[rd_addr];
    assign history_ok = FILL >= DELAY;
    assign bypass     = DELAY == '0;
    assign from_tap   = !bypass && history_ok;

    always_ff @(posedge CLK) begin
        if (CE) begin
            mem[WR_PTR] <= IN_VALUE;
        end
    end

    // Slots not yet written since reset/clear read back as zero.
    always_comb begin
        next_value = '0;
        unique case (1'b1)
            bypass:   next_value = IN_VALUE;
            from_tap: next_value = tap;
            default:  next_value = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            OUT_VALUE <= '0;
            OUT_VALID <= 1'b0;
        end else if (CE) begin
            if (CLEAR) begin
                OUT_VALUE <= '0;
                OUT_VALID <= 1'b0;
            end else begin
                OUT_VALUE <= next_value;
                OUT_VALID <= history_ok;
            end
        end
    end

endmodule

// File: rtl/multichannel_variable_delay_line.sv
// N-channel programmable delay line sharing one write pointer and fill count.
module multichannel_variable_delay_line
    import multichannel_delay_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int DATA_BITS    = 32,
    parameter int DELAY_BITS   = DELAY_BITS_DEFAULT
) (
    input  logic                              CLK,
    input  logic                              RESET,
    input  logic                              CE,
    input  logic                              CLEAR,
    input  logic [NUM_CHANNELS*DELAY_BITS-1:0] DELAY,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0]  IN_VALUE,
    output logic [NUM_CHANNELS*DATA_BITS-1:0]  OUT_VALUE,
    output logic [NUM_CHANNELS-1:0]            OUT_VALID
);

    typedef logic [DELAY_BITS-1:0] dptr_t;

    localparam dptr_t FILL_MAX = dptr_t'(depth_of(DELAY_BITS) - 1);

    dptr_t wr_ptr;
    dptr_t fill;
    dptr_t cur_ptr;
    dptr_t cur_fill;

    // A clearing edge is itself edge 0: it writes slot 0 with empty history.
    assign cur_ptr  = CLEAR ? '0 : wr_ptr;
    assign cur_fill = CLEAR ? '0 : fill;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr <= '0;
            fill   <= '0;
        end else if (CE) begin
            wr_ptr <= cur_ptr + dptr_t'(1);
            if (cur_fill != FILL_MAX) begin
                fill <= cur_fill + dptr_t'(1);
            end else begin
                fill <= cur_fill;
            end
        end
    end

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        delay_line_channel #(
            .DATA_BITS  (DATA_BITS),
            .DELAY_BITS (DELAY_BITS)
        ) u_ch (
            .CLK       (CLK),
            .RESET     (RESET),
            .CE        (CE),
            .CLEAR     (CLEAR),
            .WR_PTR    (cur_ptr),
            .FILL      (cur_fill),
            .DELAY     (DELAY[c*DELAY_BITS +: DELAY_BITS]),
            .IN_VALUE  (IN_VALUE[c*DATA_BITS +: DATA_BITS]),
            .OUT_VALUE (OUT_VALUE[c*DATA_BITS +: DATA_BITS]),
            .OUT_VALID (OUT_VALID[c])
        );
    end

endmodule

// File: tb/tb_multichannel_variable_delay_line.sv
// Directed vector bench for the multichannel variable delay line.
module tb_multichannel_variable_delay_line;

    localparam int NC = 4;
    localparam int DB = 32;
    localparam int WB = 4;
    localparam int W  = NC * DB;

    typedef struct {
        logic            ce;
        logic            clr;
        logic [NC*WB-1:0] dly;
        logic [W-1:0]    in;
        logic [W-1:0]    eo;
        logic [NC-1:0]   ev;
    } vec_t;

    logic             CLK = 1'b0;
    logic             RESET = 1'b1;
    logic             CE = 1'b0;
    logic             CLEAR = 1'b0;
    logic [NC*WB-1:0] DELAY = '0;
    logic [W-1:0]     IN_VALUE = '0;
    logic [W-1:0]     OUT_VALUE;
    logic [NC-1:0]    OUT_VALID;

    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;

    multichannel_variable_delay_line #(
        .NUM_CHANNELS (NC),
        .DATA_BITS    (DB),
        .DELAY_BITS   (WB)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .CE        (CE),
        .CLEAR     (CLEAR),
        .DELAY     (DELAY),
        .IN_VALUE  (IN_VALUE),
        .OUT_VALUE (OUT_VALUE),
        .OUT_VALID (OUT_VALID)
    );

    always #5 CLK = ~CLK;

    function automatic logic [DB-1:0] val(input int k, input int c);
        return DB'(k + 1000 * c + 1);
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h want %h", name, idx, act, exp);
        end
    endtask

    task automatic do_reset();
        CE = 1'b0;
        CLEAR = 1'b0;
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        RESET = 1'b1;
    endtask

    // Continuous ramp: after CE edge k, OUT[c] is the sample of edge k-d.
    task automatic ramp(input int k0, input int n, input logic [NC*WB-1:0] dly);
        vec_t v;
        for (int k = k0; k < k0 + n; k++) begin
            v.ce = 1'b1;
            v.clr = 1'b0;
            v.dly = dly;
            v.in = '0;
            v.eo = '0;
            v.ev = '0;
            for (int c = 0; c < NC; c++) begin
                int d;
                d = int'(dly[c*WB +: WB]);
                v.in[c*DB +: DB] = val(k, c);
                if (k >= d) begin
                    v.eo[c*DB +: DB] = val(k - d, c);
                    v.ev[c] = 1'b1;
                end
            end
            tbl.push_back(v);
        end
    endtask

    task automatic apply(input string name);
        for (int i = 0; i < tbl.size(); i++) begin
            CE = tbl[i].ce;
            CLEAR = tbl[i].clr;
            DELAY = tbl[i].dly;
            IN_VALUE = tbl[i].in;
            @(posedge CLK);
            #1;
            check({name, ".out"}, i, OUT_VALUE, tbl[i].eo);
            check({name, ".vld"}, i, W'(OUT_VALID), W'(tbl[i].ev));
        end
        tbl.delete();
        CE = 1'b0;
        CLEAR = 1'b0;
    endtask

    initial begin
        logic [NC*WB-1:0] d_b;
        logic [W-1:0]     hold_o;
        logic [NC-1:0]    hold_v;
        vec_t             v;
        int               j;
        int               k;

        d_b = {4'd15, 4'd7, 4'd3, 4'd0};

        #1 RESET = 1'b0;
        #3;
        check("rst.out", 0, OUT_VALUE, '0);
        check("rst.vld", 0, W'(OUT_VALID), '0);
        @(posedge CLK);
        #1 RESET = 1'b1;

        ramp(0, 5, '0);
        apply("d0");

        do_reset();
        ramp(0, 40, d_b);
        k = 40;
        for (int s = 0; s < 16; s++) begin
            ramp(k, 10, {d_b[NC*WB-1:WB], 4'(s)});
            k += 10;
        end
        ramp(k, 10, {d_b[NC*WB-1:WB], 4'd0});
        apply("ramp");

        do_reset();
        j = 0;
        hold_o = '0;
        hold_v = '0;
        for (int i = 0; i < 12; i++) begin
            if (i % 2 == 0) begin
                v.ce = 1'b1;
                v.clr = 1'b0;
                v.dly = {NC{4'd2}};
                for (int c = 0; c < NC; c++) begin
                    v.in[c*DB +: DB] = val(j, c);
                    hold_o[c*DB +: DB] = (j >= 2) ? val(j - 2, c) : '0;
                    hold_v[c] = (j >= 2);
                end
                j++;
            end else begin
                v.ce = 1'b0;
                v.clr = (i == 3);
                v.dly = '1;
                v.in = {NC{32'hDEADBEEF}};
            end
            v.eo = hold_o;
            v.ev = hold_v;
            tbl.push_back(v);
        end
        apply("ce");

        do_reset();
        ramp(0, 10, {NC{4'd5}});
        v.ce = 1'b1;
        v.clr = 1'b1;
        v.dly = {NC{4'd5}};
        for (int c = 0; c < NC; c++) v.in[c*DB +: DB] = val(100, c);
        v.eo = '0;
        v.ev = '0;
        tbl.push_back(v);
        for (int jj = 1; jj < 8; jj++) begin
            v.clr = 1'b0;
            v.eo = '0;
            v.ev = '0;
            for (int c = 0; c < NC; c++) begin
                v.in[c*DB +: DB] = val(100 + jj, c);
                if (jj >= 5) begin
                    v.eo[c*DB +: DB] = val(100 + jj - 5, c);
                    v.ev[c] = 1'b1;
                end
            end
            tbl.push_back(v);
        end
        apply("clr");

        do_reset();
        ramp(0, 6, d_b);
        apply("pre");
        #2 RESET = 1'b0;
        #1;
        check("arst.out", 0, OUT_VALUE, '0);
        check("arst.vld", 0, W'(OUT_VALID), '0);
        CE = 1'b1;
        IN_VALUE = {NC{32'h12345678}};
        @(posedge CLK);
        #1;
        check("arst.out", 1, OUT_VALUE, '0);
        check("arst.vld", 1, W'(OUT_VALID), '0);
        CE = 1'b0;
        #2 RESET = 1'b1;
        ramp(0, 20, d_b);
        apply("post");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
